// File: rtl/fc_pkg.sv
// -----------------------------------------------------------------------------
// fc_pkg
// Shared definitions for the fully-connected layer engine.
//   fc_state_t : controller states
//   addr_w     : address/counter width for n entries (never below 1 bit)
//   sext       : sign-extend the low w bits of a 64-bit vector
// -----------------------------------------------------------------------------
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACC     = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_OUT_RD  = 3'd3,
        ST_OUT_VLD = 3'd4,
        ST_DONE    = 3'd5
    } fc_state_t;

    // A single-entry space still needs a 1-bit port so the port list stays legal.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
        logic [63:0] s;
        s = v << (64 - w);
        return $signed(s) >>> (64 - w);
    endfunction

endpackage

// File: rtl/fc_requant.sv
// -----------------------------------------------------------------------------
// fc_requant
// Combinational per-lane requantiser: bias add, round-half-up arithmetic shift,
// optional ReLU and saturation to a DW-bit signed result.
//   i_acc  : accumulated dot product (ACCW, signed)
//   i_bias : lane bias (WW, signed)
//   o_dout : requantised result (DW, signed)
// -----------------------------------------------------------------------------
module fc_requant #(
    parameter int DW        = 18,
    parameter int WW        = 9,
    parameter int ACCW      = 35,
    parameter int OUT_SHIFT = 0,
    parameter int RELU      = 1
) (
    input  logic signed [ACCW-1:0] i_acc,
    input  logic signed [WW-1:0]   i_bias,
    output logic signed [DW-1:0]   o_dout
);
    // Two guard bits: one for the bias add, one for the rounding add.
    localparam int TW = ACCW + 2;
    localparam logic signed [TW-1:0] MAXV = (TW'(1) <<< (DW - 1)) - TW'(1);
    localparam logic signed [TW-1:0] MINV = -MAXV - TW'(1);

    logic signed [TW-1:0] w_t;
    logic signed [TW-1:0] w_r;
    logic signed [TW-1:0] w_c;

    assign w_t = TW'(i_acc) + TW'(i_bias);

    generate
        if (OUT_SHIFT > 0) begin : g_shift
            localparam logic signed [TW-1:0] RND = TW'(1) <<< (OUT_SHIFT - 1);
            assign w_r = (w_t + RND) >>> OUT_SHIFT;
        end else begin : g_noshift
            assign w_r = w_t;
        end
    endgenerate

    assign w_c    = ((RELU != 0) && (w_r < 0)) ? '0 : w_r;
    assign o_dout = (w_c > MAXV) ? DW'(MAXV) :
                    (w_c < MINV) ? DW'(MINV) : DW'(w_c);

endmodule

// File: rtl/fc_layer_gen.sv
// -----------------------------------------------------------------------------
// fc_layer_gen
// Fully-connected layer: N_LANES*N_GROUP neurons over N_IN serial inputs.
// Each accepted input is multiplied against N_GROUP weight words (one per
// cycle), accumulated per lane/group, then each group is requantised and
// streamed out with a valid/ready handshake.
//   clk, rst_n          : clock, synchronous active-low reset
//   strt, tx_done       : start pulse (IDLE only), abort to IDLE
//   din, din_vld/rdy    : serial input stream
//   w_addr, w_data      : weight read port (data one cycle after address)
//   b_addr, b_data      : bias read port (data one cycle after address)
//   dout, dout_grp      : result group, lane l at [l*DW +: DW]
//   out_vld, out_rdy    : output handshake
//   busy, done          : status; done pulses after the last group is taken
// -----------------------------------------------------------------------------
module fc_layer_gen
    import fc_pkg::*;
#(
    parameter int N_IN      = 100,
    parameter int N_LANES   = 16,
    parameter int N_GROUP   = 4,
    parameter int DW        = 18,
    parameter int WW        = 9,
    parameter int ACCW      = DW + WW + $clog2(N_IN) + 1,
    parameter int OUT_SHIFT = 0,
    parameter int RELU      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  strt,
    input  logic                                  tx_done,
    input  logic [DW-1:0]                         din,
    input  logic                                  din_vld,
    output logic                                  din_rdy,
    output logic [addr_w(N_IN*N_GROUP)-1:0]       w_addr,
    input  logic [N_LANES*WW-1:0]                 w_data,
    output logic [addr_w(N_GROUP)-1:0]            b_addr,
    input  logic [N_LANES*WW-1:0]                 b_data,
    output logic [N_LANES*DW-1:0]                 dout,
    output logic [addr_w(N_GROUP)-1:0]            dout_grp,
    output logic                                  out_vld,
    input  logic                                  out_rdy,
    output logic                                  busy,
    output logic                                  done
);
    localparam int AW = addr_w(N_IN * N_GROUP);
    localparam int IW = addr_w(N_IN);
    localparam int GW = addr_w(N_GROUP);

    fc_state_t              r_state;
    logic [IW-1:0]          r_in_idx;
    logic [GW-1:0]          r_grp;
    logic [GW-1:0]          r_og;
    logic signed [DW-1:0]   r_din_q;
    logic                   r_mac_vld;
    logic                   r_mac_first;
    logic [GW-1:0]          r_mac_grp;

    logic w_last_grp;
    logic w_last_in;
    logic w_issue;

    assign w_last_grp = (r_grp == GW'(N_GROUP - 1));
    assign w_last_in  = (r_in_idx == IW'(N_IN - 1));
    // Group 0 waits for a sample; the remaining groups reuse the latched one.
    assign w_issue    = (r_state == ST_ACC) && ((r_grp != '0) || din_vld);

    assign din_rdy  = (r_state == ST_ACC) && (r_grp == '0);
    assign w_addr   = AW'(int'(r_in_idx) * N_GROUP + int'(r_grp));
    assign b_addr   = r_og;
    assign dout_grp = r_og;
    assign out_vld  = (r_state == ST_OUT_VLD);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_idx    <= '0;
            r_grp       <= '0;
            r_og        <= '0;
            r_din_q     <= '0;
            r_mac_vld   <= 1'b0;
            r_mac_first <= 1'b0;
            r_mac_grp   <= '0;
        end else if (tx_done) begin
            r_state   <= ST_IDLE;
            r_in_idx  <= '0;
            r_grp     <= '0;
            r_og      <= '0;
            r_mac_vld <= 1'b0;
        end else begin
            // MAC stage trails the issue stage by exactly one cycle so that
            // w_data for the issued address is present when it executes.
            r_mac_vld   <= w_issue;
            r_mac_grp   <= r_grp;
            r_mac_first <= (r_in_idx == '0);
            if (w_issue && (r_grp == '0)) begin
                r_din_q <= din;
            end
            case (r_state)
                ST_IDLE: begin
                    if (strt) begin
                        r_state  <= ST_ACC;
                        r_in_idx <= '0;
                        r_grp    <= '0;
                        r_og     <= '0;
                    end
                end
                ST_ACC: begin
                    if (w_issue) begin
                        if (w_last_grp) begin
                            r_grp <= '0;
                            if (w_last_in) begin
                                r_in_idx <= '0;
                                r_state  <= ST_FLUSH;
                            end else begin
                                r_in_idx <= r_in_idx + IW'(1);
                            end
                        end else begin
                            r_grp <= r_grp + GW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    r_og    <= '0;
                    r_state <= ST_OUT_RD;
                end
                ST_OUT_RD: begin
                    r_state <= ST_OUT_VLD;
                end
                ST_OUT_VLD: begin
                    if (out_rdy) begin
                        if (r_og == GW'(N_GROUP - 1)) begin
                            r_og    <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_og    <= r_og + GW'(1);
                            r_state <= ST_OUT_RD;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            logic signed [ACCW-1:0] r_acc [N_GROUP];
            logic signed [ACCW-1:0] w_prod;
            logic signed [ACCW-1:0] w_base;
            logic signed [DW-1:0]   w_lane_out;

            assign w_prod = ACCW'(r_din_q) * ACCW'(sext(64'(w_data[gi*WW +: WW]), WW));
            // The first input of a run overwrites, so no explicit clear is needed.
            assign w_base = r_mac_first ? '0 : r_acc[r_mac_grp];

            always_ff @(posedge clk) begin
                if (r_mac_vld) begin
                    r_acc[r_mac_grp] <= w_base + w_prod;
                end
            end

            fc_requant #(
                .DW        (DW),
                .WW        (WW),
                .ACCW      (ACCW),
                .OUT_SHIFT (OUT_SHIFT),
                .RELU      (RELU)
            ) u_requant (
                .i_acc  (r_acc[r_og]),
                .i_bias (b_data[gi*WW +: WW]),
                .o_dout (w_lane_out)
            );

            assign dout[gi*DW +: DW] = out_vld ? w_lane_out : '0;
        end
    endgenerate

endmodule

// File: tb/tb_fc_layer_gen.sv
// -----------------------------------------------------------------------------
// tb_fc_layer_gen
// Three instances share stimulus: u0 plain, u1 with ReLU, u2 with OUT_SHIFT=2.
// Expected groups are queued when a run starts and popped on each output
// handshake.
// -----------------------------------------------------------------------------
module tb_fc_layer_gen;
    localparam int N_IN = 3;
    localparam int NL   = 2;
    localparam int NG   = 2;
    localparam int DW   = 8;
    localparam int WW   = 9;
    localparam int NU   = 3;

    typedef struct {
        int grp;
        int d0;
        int d1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          strt = 1'b0;
    logic          tx_done = 1'b0;
    logic          din_vld = 1'b0;
    logic          out_rdy = 1'b1;
    logic [DW-1:0] din = '0;

    logic             din_rdy_a  [NU];
    logic [2:0]       w_addr_a   [NU];
    logic [0:0]       b_addr_a   [NU];
    logic [NL*DW-1:0] dout_a     [NU];
    logic [0:0]       dout_grp_a [NU];
    logic             out_vld_a  [NU];
    logic             busy_a     [NU];
    logic             done_a     [NU];

    int wt [N_IN][NG][NL];
    int bs [NG][NL];
    int xin [N_IN];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt [NU];
    int cyc = 0;
    int s_cyc = 0;
    bit lat_arm = 0;
    bit lat_en = 0;
    bit stall_en = 0;
    int stall_left = 0;
    bit stall_prev = 0;
    logic [NL*DW-1:0] prev_dout;
    logic [0:0]       prev_grp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NL*WW-1:0] pack_w(input logic [2:0] a);
        logic [NL*WW-1:0] v;
        int i;
        int g;
        v = '0;
        i = int'(a) / NG;
        g = int'(a) % NG;
        if (i < N_IN) begin
            for (int l = 0; l < NL; l++) v[l*WW +: WW] = WW'(wt[i][g][l]);
        end
        return v;
    endfunction

    function automatic logic [NL*WW-1:0] pack_b(input logic [0:0] a);
        logic [NL*WW-1:0] v;
        for (int l = 0; l < NL; l++) v[l*WW +: WW] = WW'(bs[int'(a)][l]);
        return v;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NU; gi++) begin : g_dut
            logic [NL*WW-1:0] w_data;
            logic [NL*WW-1:0] b_data;
            always @(posedge clk) begin
                w_data <= pack_w(w_addr_a[gi]);
                b_data <= pack_b(b_addr_a[gi]);
            end
            fc_layer_gen #(
                .N_IN      (N_IN),
                .N_LANES   (NL),
                .N_GROUP   (NG),
                .DW        (DW),
                .WW        (WW),
                .OUT_SHIFT ((gi == 2) ? 2 : 0),
                .RELU      ((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .strt     (strt),
                .tx_done  (tx_done),
                .din      (din),
                .din_vld  (din_vld),
                .din_rdy  (din_rdy_a[gi]),
                .w_addr   (w_addr_a[gi]),
                .w_data   (w_data),
                .b_addr   (b_addr_a[gi]),
                .b_data   (b_data),
                .dout     (dout_a[gi]),
                .dout_grp (dout_grp_a[gi]),
                .out_vld  (out_vld_a[gi]),
                .out_rdy  (out_rdy),
                .busy     (busy_a[gi]),
                .done     (done_a[gi])
            );
        end
    endgenerate

    // Reference: dot product, bias, round-half-up shift, ReLU, clamp to 8 bits.
    function automatic int model(input int k, input int g, input int l);
        longint acc;
        longint t;
        longint r;
        int sh;
        sh  = (k == 2) ? 2 : 0;
        acc = 0;
        for (int i = 0; i < N_IN; i++) acc += longint'(xin[i]) * longint'(wt[i][g][l]);
        t = acc + longint'(bs[g][l]);
        if (sh > 0) r = (t + (longint'(1) << (sh - 1))) >>> sh;
        else        r = t;
        if (k == 1 && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int k);
        case (k)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int k = 0; k < NU; k++) begin
            for (int g = 0; g < NG; g++) begin
                e.grp = g;
                e.d0  = model(k, g, 0);
                e.d1  = model(k, g, 1);
                case (k)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
    endtask

    // Output monitor: scoreboard pops, stall stability, done pulses, latency.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < NU; k++) begin
                if (done_a[k]) done_cnt[k]++;
                if (out_vld_a[k] && out_rdy) begin
                    chk($sformatf("u%0d_unexpected_group", k), longint'(qsize(k) > 0), 1);
                    if (qsize(k) > 0) begin
                        e = qpop(k);
                        $display("u%0d grp %0d: lane0 %0d lane1 %0d (exp %0d %0d)", k,
                                 dout_grp_a[k], $signed(dout_a[k][DW-1:0]),
                                 $signed(dout_a[k][2*DW-1:DW]), e.d0, e.d1);
                        chk($sformatf("u%0d_grp", k), longint'(dout_grp_a[k]), e.grp);
                        chk($sformatf("u%0d_lane0", k), $signed(dout_a[k][DW-1:0]), e.d0);
                        chk($sformatf("u%0d_lane1", k), $signed(dout_a[k][2*DW-1:DW]), e.d1);
                    end
                end
            end
            if (stall_prev) begin
                chk("stall_vld", longint'(out_vld_a[0]), 1);
                chk("stall_dout", longint'(dout_a[0]), longint'(prev_dout));
                chk("stall_grp", longint'(dout_grp_a[0]), longint'(prev_grp));
            end
            stall_prev = out_vld_a[0] && !out_rdy;
            prev_dout  = dout_a[0];
            prev_grp   = dout_grp_a[0];
            if (strt && !busy_a[0]) begin
                s_cyc   = cyc;
                lat_arm = 1;
            end
            if (lat_arm && out_vld_a[0]) begin
                lat_arm = 0;
                if (lat_en) chk("latency", longint'(cyc - s_cyc), N_IN * NG + 3);
            end
        end
    end

    // Consumer: optionally holds off group 1 for three cycles.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en && stall_left > 0 && out_vld_a[0] && dout_grp_a[0] == 1'b1) begin
                out_rdy = 1'b0;
                stall_left--;
            end else begin
                out_rdy = 1'b1;
            end
        end
    end

    task automatic set_all(input int w, input int b);
        for (int i = 0; i < N_IN; i++)
            for (int g = 0; g < NG; g++)
                for (int l = 0; l < NL; l++) wt[i][g][l] = w;
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < NL; l++) bs[g][l] = b;
    endtask

    task automatic set_rand();
        for (int i = 0; i < N_IN; i++) begin
            xin[i] = int'($urandom_range(40)) - 20;
            for (int g = 0; g < NG; g++)
                for (int l = 0; l < NL; l++) wt[i][g][l] = int'($urandom_range(200)) - 100;
        end
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < NL; l++) bs[g][l] = int'($urandom_range(100)) - 50;
    endtask

    task automatic set_x(input int a, input int b, input int c);
        xin[0] = a;
        xin[1] = b;
        xin[2] = c;
    endtask

    // One full run; entered and left 1 time unit after a rising edge.
    task automatic run(input int gap, input bit lat, input bit stall, input bit strt_noise);
        int cnt;
        int d0c [NU];
        push_expected();
        for (int k = 0; k < NU; k++) d0c[k] = done_cnt[k];
        lat_en     = lat;
        stall_en   = stall;
        stall_left = stall ? 3 : 0;
        strt = 1'b1;
        @(posedge clk); #1;
        strt = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            din     = DW'(xin[i]);
            din_vld = 1'b1;
            cnt     = 0;
            while (!din_rdy_a[0] && cnt < 50) begin
                @(posedge clk); #1;
                cnt++;
            end
            chk("din_rdy_timeout", longint'(cnt < 50), 1);
            @(posedge clk); #1;
            din_vld = 1'b0;
            if (gap > 0) begin
                strt = strt_noise;
                repeat (gap) begin
                    @(posedge clk); #1;
                end
                strt = 1'b0;
            end
        end
        cnt = 0;
        while (!done_a[0] && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("done_seen", longint'(done_a[0]), 1);
        @(posedge clk); #1;
        for (int k = 0; k < NU; k++) begin
            chk($sformatf("u%0d_done_once", k), longint'(done_cnt[k] - d0c[k]), 1);
            chk($sformatf("u%0d_idle_after", k), longint'(busy_a[k]), 0);
            chk($sformatf("u%0d_q_drained", k), longint'(qsize(k)), 0);
        end
        stall_en = 0;
        lat_en   = 0;
    endtask

    initial begin
        for (int k = 0; k < NU; k++) done_cnt[k] = 0;
        set_all(0, 0);
        set_x(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NU; k++) begin
            chk($sformatf("u%0d_rst_busy", k), longint'(busy_a[k]), 0);
            chk($sformatf("u%0d_rst_vld", k), longint'(out_vld_a[k]), 0);
            chk($sformatf("u%0d_rst_done", k), longint'(done_a[k]), 0);
            chk($sformatf("u%0d_rst_rdy", k), longint'(din_rdy_a[k]), 0);
            chk($sformatf("u%0d_rst_dout", k), longint'(dout_a[k]), 0);
            chk($sformatf("u%0d_rst_waddr", k), longint'(w_addr_a[k]), 0);
            chk($sformatf("u%0d_rst_baddr", k), longint'(b_addr_a[k]), 0);
        end

        // Basic sum: 1+2+3 = 6 everywhere, 6 >>> 2 rounds to 2.
        set_all(1, 0);  set_x(1, 2, 3);   run(0, 1, 0, 0);
        // Negative weights with bias: -5, ReLU 0, shifted -1.
        set_all(-1, 1); set_x(1, 2, 3);   run(0, 1, 0, 0);
        // Rounding cases: 5 -> 1, -6 -> -1.
        set_all(1, 0);  set_x(1, 2, 2);   run(0, 0, 0, 0);
        set_all(1, 0);  set_x(-1, -2, -3); run(0, 0, 0, 0);
        // Saturation: +300 -> 127, -300 -> -128.
        set_all(100, 0);  set_x(1, 1, 1); run(0, 0, 0, 0);
        set_all(-100, 0); set_x(1, 1, 1); run(0, 0, 0, 0);

        // Same random data without and with input gaps / output stall.
        set_rand();
        run(0, 1, 0, 0);
        run(2, 0, 1, 1);

        // Abort at in_idx=1, then a simultaneous strt+tx_done in IDLE.
        set_all(7, 3); set_x(9, 9, 9);
        strt = 1'b1;
        @(posedge clk); #1;
        strt    = 1'b0;
        din     = DW'(9);
        din_vld = 1'b1;
        chk("abort_rdy", longint'(din_rdy_a[0]), 1);
        @(posedge clk); #1;
        din_vld = 1'b0;
        @(posedge clk); #1;
        chk("abort_waddr", longint'(w_addr_a[0]), 2);
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        for (int k = 0; k < NU; k++) begin
            chk($sformatf("u%0d_abort_busy", k), longint'(busy_a[k]), 0);
            chk($sformatf("u%0d_abort_rdy", k), longint'(din_rdy_a[k]), 0);
        end
        strt    = 1'b1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        strt    = 1'b0;
        tx_done = 1'b0;
        chk("strt_with_abort", longint'(busy_a[0]), 0);

        // Fresh runs after the abort must not see stale sums.
        for (int r = 0; r < 3; r++) begin
            set_rand();
            run(r, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
